// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// Optional forwarding is selected with ALU_ISSUE_FWD_EN.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } issue_state_t;

    localparam logic [1:0] USEFUNC_R = 2'b00;
    localparam logic [3:0] FUNC_MUL  = 4'b1000;
    localparam int         CNT_W     = 4;

    function automatic logic is_mul(
        input logic [1:0] use_func,
        input logic [3:0] func
    );
        return (use_func == USEFUNC_R) && (func == FUNC_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_timer.sv
// Occupancy counter for multi-cycle multiplies.
// Runs 0..MUL_LAT-1 while enabled; done flags the last cycle.
import alu_issue_pkg::*;

module alu_mul_timer #(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done;

    assign w_done = (r_cnt == CNT_LAST);
    assign o_done = w_done;

    // Next count: restart on load/clear or when the final cycle ends.
    always_comb begin
        w_cnt_nxt = '0;
        if (i_clr || i_load) begin
            w_cnt_nxt = '0;
        end else if (i_en && !w_done) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-slot EX issue controller with multiply stretching and WB tracking.
// Define ALU_ISSUE_FWD_EN for operand forwarding instead of RAW stalls.
import alu_issue_pkg::*;

module alu_issue_ctrl #(
    parameter int REG_BITS = 4,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inValid,
    output logic                inReady,
    input  logic [1:0]          inUseFunc,
    input  logic [3:0]          inFunc,
    input  logic [REG_BITS-1:0] inRs,
    input  logic [REG_BITS-1:0] inRt,
    input  logic [REG_BITS-1:0] inRd,
    input  logic                inWrite,
    input  logic                flush,
    output logic                exValid,
    output logic                exDone,
    output logic [1:0]          exUseFunc,
    output logic [3:0]          exFunc,
    output logic [REG_BITS-1:0] exRd,
    output logic                exWrite,
    output logic                fwdA,
    output logic                fwdB,
    output logic                busy,
    output logic                wbValid,
    output logic [REG_BITS-1:0] wbRd,
    output logic                wbWrite
);

    issue_state_t r_state;
    issue_state_t w_state_nxt;

    logic [1:0]          r_ex_uf;
    logic [3:0]          r_ex_func;
    logic [REG_BITS-1:0] r_ex_rd;
    logic                r_ex_wr;
    logic                r_wb_v;
    logic [REG_BITS-1:0] r_wb_rd;
    logic                r_wb_wr;

    logic w_ex_valid;
    logic w_ex_done;
    logic w_mul_done;
    logic w_in_mul;
    logic w_dep_a;
    logic w_dep_b;
    logic w_raw_stall;
    logic w_ready;
    logic w_accept;
    logic w_retire;

    assign w_ex_valid = (r_state != ST_IDLE);
    assign w_in_mul   = is_mul(inUseFunc, inFunc);

    assign w_ex_done = (r_state == ST_EXEC)
                     || ((r_state == ST_MUL) && w_mul_done);

    // Register 0 is hardwired, so it never creates a dependency.
    assign w_dep_a = w_ex_valid && r_ex_wr
                   && (r_ex_rd != '0) && (inRs == r_ex_rd);
    assign w_dep_b = w_ex_valid && r_ex_wr
                   && (r_ex_rd != '0) && (inRt == r_ex_rd);

`ifdef ALU_ISSUE_FWD_EN
    assign w_raw_stall = 1'b0;
`else
    // One bubble lets the producer reach WB for write-through.
    assign w_raw_stall = w_dep_a || w_dep_b;
`endif

    assign w_ready  = !flush && (!w_ex_valid || w_ex_done) && !w_raw_stall;
    assign w_accept = inValid && w_ready;
    assign w_retire = w_ex_valid && w_ex_done && !flush;

    alu_mul_timer #(
        .MUL_LAT (MUL_LAT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept && w_in_mul),
        .i_clr  (flush),
        .i_en   (r_state == ST_MUL),
        .o_done (w_mul_done)
    );

    // Next EX state: flush wins, then a new accept, then drain.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_in_mul ? ST_MUL : ST_EXEC;
        end else if (w_ex_done) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // EX operation fields, captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_uf   <= '0;
            r_ex_func <= '0;
            r_ex_rd   <= '0;
            r_ex_wr   <= 1'b0;
        end else if (w_accept) begin
            r_ex_uf   <= inUseFunc;
            r_ex_func <= inFunc;
            r_ex_rd   <= inRd;
            r_ex_wr   <= inWrite;
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    logic r_fwd_a;
    logic r_fwd_b;

    // Forward flags follow the op they were computed for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a <= 1'b0;
            r_fwd_b <= 1'b0;
        end else if (flush) begin
            r_fwd_a <= 1'b0;
            r_fwd_b <= 1'b0;
        end else if (w_accept) begin
            r_fwd_a <= w_dep_a;
            r_fwd_b <= w_dep_b;
        end else if (w_ex_done) begin
            r_fwd_a <= 1'b0;
            r_fwd_b <= 1'b0;
        end
    end

    assign fwdA = r_fwd_a;
    assign fwdB = r_fwd_b;
`else
    assign fwdA = 1'b0;
    assign fwdB = 1'b0;
`endif

    // WB tracking: a completing, unflushed op retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_v  <= 1'b0;
            r_wb_rd <= '0;
            r_wb_wr <= 1'b0;
        end else begin
            r_wb_v <= w_retire;
            if (w_retire) begin
                r_wb_rd <= r_ex_rd;
                r_wb_wr <= r_ex_wr;
            end
        end
    end

    assign inReady   = w_ready;
    assign exValid   = w_ex_valid;
    assign exDone    = w_ex_done;
    assign exUseFunc = r_ex_uf;
    assign exFunc    = r_ex_func;
    assign exRd      = r_ex_rd;
    assign exWrite   = r_ex_wr;
    assign busy      = (r_state == ST_MUL);
    assign wbValid   = r_wb_v;
    assign wbRd      = r_wb_rd;
    assign wbWrite   = r_wb_wr;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and sequencing controller that sits between the decode stage and the ALU control/datapath. It accepts decoded operations over a valid/ready handshake and holds each one in a single EX slot. It stretches multi-cycle multiply operations over a fixed latency, and retires completed operations into a WB tracking register. It also produces the `fwdA`/`fwdB` operand-forwarding flags consumed by the ALU control decoder, or stalls on read-after-write hazards when forwarding is compiled out.

## Interface
Parameters:
- `REG_BITS`, default 4: register address width.
- `MUL_LAT`, default 4: EX occupancy in cycles of a multiply. Legal range 2..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inValid` in 1: decode offers an operation.
- `inReady` out 1: controller accepts this cycle (combinational).
- `inUseFunc` in 2, `inFunc` in 4: operation class and function code.
- `inRs`, `inRt`, `inRd` in REG_BITS: source A, source B and destination addresses.
- `inWrite` in 1: operation writes `inRd`.
- `flush` in 1: kill the EX operation and block acceptance.
- `exValid` out 1: EX slot occupied.
- `exDone` out 1: EX operation completes this cycle.
- `exUseFunc` out 2, `exFunc` out 4, `exRd` out REG_BITS, `exWrite` out 1: EX operation fields.
- `fwdA`, `fwdB` out 1: operand A/B of the EX op is taken from the previous op's result.
- `busy` out 1: multiply in progress.
- `wbValid` out 1, `wbRd` out REG_BITS, `wbWrite` out 1: retired operation.

## Operation
- Accept when `inValid && inReady`. Define `inReady = !flush && (!exValid || exDone) && !rawStall`.
- States:
  - IDLE: EX empty.
  - EXEC: single-cycle op in EX; `exDone=1`.
  - MUL: multiply in EX. Counter `cnt` runs 0..MUL_LAT-1, and `exDone=1` only when `cnt==MUL_LAT-1`.
- A multiply is `inUseFunc==2'b00 && inFunc==4'b1000`. All other codes are single-cycle.
- Transitions:
  - Accepting a multiply goes to MUL with `cnt=0`.
  - Accepting any other op goes to EXEC.
  - `exDone` with no accept goes to IDLE.
  - In MUL, `cnt` increments each cycle until done.
- Hazard condition `dep(x)` = `x==exRd && exWrite && exValid && exRd!=0`, evaluated at acceptance against the op completing in EX.
- With forwarding enabled, `rawStall=0`. On accept, the next-cycle values are `fwdA<=dep(inRs)` and `fwdB<=dep(inRt)`.
- Register 0 never forwards and never stalls.
- Retirement: `wbValid<=exValid&&exDone&&!flush`. `wbRd` and `wbWrite` capture `exRd` and `exWrite` on retirement. `wbValid` is otherwise cleared.
- `flush`:
  - The next cycle has `exValid=0`, state IDLE, `cnt=0`, `fwdA`/`fwdB` = 0.
  - The flushed op does not retire, even when `exDone` was 1.
  - Nothing is accepted in the flush cycle.
- Reset values: all registered outputs 0, state IDLE, `cnt=0`. After reset, `inReady=1` while `flush=0`.

## Timing
- Accept-to-EX latency is 1 cycle. EX fields, `fwdA` and `fwdB` are registered and valid with `exValid`.
- A single-cycle op occupies EX for 1 cycle. Back-to-back ops sustain 1 op per cycle.
- A multiply occupies EX for exactly MUL_LAT cycles. `inReady=0` for the first MUL_LAT-1 of them. A new op is accepted in the `exDone` cycle, giving zero bubbles.
- `busy` is 1 for all MUL_LAT cycles. It is 0 on the cycle after MUL completes unless another multiply is accepted.
- `wbValid` is asserted 1 cycle after `exDone`.
- Reset assertion mid-multiply clears state immediately and asynchronously. No retirement occurs.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding as described, with no RAW stalls.
- `ALU_ISSUE_FWD_EN` undefined:
  - `fwdA` and `fwdB` are tied 0.
  - `rawStall = dep(inRs) || dep(inRt)`, which inserts one bubble. The producer moves to WB, and the register file's write-through supplies the value.
  - Hazards against WB never stall.

## Structure
- Package `alu_issue_pkg`:
  - State enum IDLE/EXEC/MUL.
  - Constants `USEFUNC_R=2'b00` and `FUNC_MUL=4'b1000`.
  - Multiply-detect function.
- Sub-module `alu_mul_timer`: load, count-enable and done logic for `cnt`, parameterised by MUL_LAT.
- The remaining FSM, hazard compare and EX/WB registers are in `alu_issue_ctrl`.

## Test plan
- Reset, then 3 single-cycle ops back-to-back (rd=1,2,3, independent) → `inReady` stays 1; `exValid` runs 3 cycles; `wbValid` follows each by 1 cycle with `wbRd` 1,2,3.
- Multiply (useFunc=00, func=1000, MUL_LAT=4) followed by an add offered immediately → `busy`=1 for 4 cycles; `inReady`=0 for 3 cycles; add accepted in the 4th cycle; `wbRd` of the multiply appears 1 cycle after `exDone`.
- Forwarding enabled: op rd=5 then op rs=5 rt=5 → second op in EX with `fwdA=fwdB=1`, no bubble. Repeat with rd=0 → `fwdA=fwdB=0`.
- `ALU_ISSUE_FWD_EN` undefined, same sequence with rd=5 → exactly one cycle with `inReady=0`; second op issues with `fwdA=fwdB=0`.
- `flush` in cycle 2 of a multiply → next cycle `exValid=0`, `busy=0`, no `wbValid`; op offered with `flush` low accepted the following cycle.
- Assert `rst_n` low mid-multiply → all outputs 0 immediately; after release, `inReady=1` and a new op issues normally.
